// File: rtl/mem_seq_if.sv
// Bundle connecting the memory-access sequencer to its control unit,
// to the IMEM/DMEM macros and to the register bank.
interface mem_seq_if #(
  parameter int INST_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int IADDR_WIDTH = 8,
  parameter int DADDR_WIDTH = 8
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [DADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   jump;
  logic [IADDR_WIDTH-1:0] jump_addr;
  logic                   done;
  logic [IADDR_WIDTH-1:0] pc;
  logic                   imem_en;
  logic [IADDR_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0]  imem_rdata;
  logic                   dmem_en;
  logic                   dmem_we;
  logic [DADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0]  dmem_wdata;
  logic [DATA_WIDTH-1:0]  dmem_rdata;
  logic                   opcode_update;
  logic                   imem_update;
  logic [INST_WIDTH-1:0]  imem_data;
  logic                   dmem_update;
  logic [DATA_WIDTH-1:0]  dmem_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, jump, jump_addr,
           imem_rdata, dmem_rdata,
    output req_ready, done, pc, imem_en, imem_addr, dmem_en, dmem_we,
           dmem_addr, dmem_wdata, opcode_update, imem_update, imem_data,
           dmem_update, dmem_data
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, jump, jump_addr,
           imem_rdata, dmem_rdata,
    input  req_ready, done, pc, imem_en, imem_addr, dmem_en, dmem_we,
           dmem_addr, dmem_wdata, opcode_update, imem_update, imem_data,
           dmem_update, dmem_data
  );
endinterface

// File: rtl/mem_seq.sv
// Memory-access sequencer: owns the PC, issues IMEM/DMEM accesses for the
// control unit and hands read data to the register bank with update strobes.
module mem_seq #(
  parameter int                     INST_WIDTH  = 16,
  parameter int                     DATA_WIDTH  = 8,
  parameter int                     IADDR_WIDTH = 8,
  parameter int                     DADDR_WIDTH = 8,
  parameter logic [IADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic       clk,
  input  logic       rst,
  mem_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, IREAD, DREAD, DWRITE} state_t;

  state_t                 state_reg, state_next;
  logic [IADDR_WIDTH-1:0] pc_reg, pc_next;
  logic                   imm_reg, imm_next;
  logic [INST_WIDTH-1:0]  idata_reg;
  logic [DATA_WIDTH-1:0]  ddata_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      imm_reg   <= 1'b0;
      idata_reg <= '0;
      ddata_reg <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      imm_reg   <= imm_next;
      if (state_reg == IREAD) idata_reg <= bus.imem_rdata;
      if (state_reg == DREAD) ddata_reg <= bus.dmem_rdata;
    end
  end

  assign bus.pc = pc_reg;

  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    imm_next          = imm_reg;
    bus.req_ready     = 1'b0;
    bus.done          = 1'b0;
    bus.imem_en       = 1'b0;
    bus.imem_addr     = pc_reg;
    bus.dmem_en       = 1'b0;
    bus.dmem_we       = 1'b0;
    bus.dmem_addr     = '0;
    bus.dmem_wdata    = '0;
    bus.opcode_update = 1'b0;
    bus.imem_update   = 1'b0;
    bus.dmem_update   = 1'b0;
    bus.imem_data     = idata_reg;
    bus.dmem_data     = ddata_reg;

    case (state_reg)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.imem_addr = bus.jump ? bus.jump_addr : pc_reg;
        if (bus.jump) pc_next = bus.jump_addr;
        // Gating with rst keeps the memory enables quiet while reset is held.
        if (rst && bus.req_valid) begin
          case (bus.req_op)
            2'b00, 2'b01: begin
              bus.imem_en = 1'b1;
              imm_next    = bus.req_op[0];
              state_next  = IREAD;
            end
            2'b10: begin
              bus.dmem_en   = 1'b1;
              bus.dmem_addr = bus.req_addr;
              state_next    = DREAD;
            end
            default: begin
              bus.dmem_en    = 1'b1;
              bus.dmem_we    = 1'b1;
              bus.dmem_addr  = bus.req_addr;
              bus.dmem_wdata = bus.req_wdata;
              state_next     = DWRITE;
            end
          endcase
        end
      end
      IREAD: begin
        bus.imem_data     = bus.imem_rdata;
        bus.opcode_update = !imm_reg;
        bus.imem_update   = imm_reg;
        bus.done          = 1'b1;
        pc_next           = pc_reg + IADDR_WIDTH'(1);
        state_next        = IDLE;
      end
      DREAD: begin
        bus.dmem_data   = bus.dmem_rdata;
        bus.dmem_update = 1'b1;
        bus.done        = 1'b1;
        state_next      = IDLE;
      end
      default: begin
        bus.done   = 1'b1;
        state_next = IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_mem_seq.sv
// Randomized bench for mem_seq: sync memory macros, a transaction-level
// reference model compared every cycle, plus directed literal pins.
module tb_mem_seq;
  localparam logic [7:0] RPC = 8'h10;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  mem_seq_if #(.INST_WIDTH(16), .DATA_WIDTH(8), .IADDR_WIDTH(8), .DADDR_WIDTH(8)) bus ();

  mem_seq #(
    .INST_WIDTH(16), .DATA_WIDTH(8), .IADDR_WIDTH(8), .DADDR_WIDTH(8),
    .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory macros (one-cycle read latency)
  logic [15:0] imem   [256];
  logic [7:0]  dmem   [256];
  logic [7:0]  shadow [256];

  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= imem[bus.imem_addr];
    if (bus.dmem_en) begin
      if (bus.dmem_we) dmem[bus.dmem_addr] <= bus.dmem_wdata;
      else             bus.dmem_rdata      <= dmem[bus.dmem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding request at most, described by its kind
  // and the address it targets; expected data come from the memory images.
  logic [7:0]  m_pc;
  bit          m_busy;
  logic [1:0]  m_kind;
  logic [7:0]  m_faddr, m_laddr;
  logic [15:0] m_ihold;
  logic [7:0]  m_dhold;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_ready", bus.req_ready, 1);
      chk("rst_done", bus.done, 0);
      chk("rst_imem_en", bus.imem_en, 0);
      chk("rst_dmem_en", bus.dmem_en, 0);
      chk("rst_dmem_we", bus.dmem_we, 0);
      chk("rst_strobes", {bus.opcode_update, bus.imem_update, bus.dmem_update}, 0);
      chk("rst_imem_data", bus.imem_data, 0);
      chk("rst_dmem_data", bus.dmem_data, 0);
      chk("rst_dmem_addr", bus.dmem_addr, 0);
      chk("rst_dmem_wdata", bus.dmem_wdata, 0);
      chk("rst_pc", bus.pc, RPC);
      m_pc = RPC; m_busy = 0; m_ihold = '0; m_dhold = '0;
    end else if (!m_busy) begin
      logic [7:0] faddr;
      faddr = bus.jump ? bus.jump_addr : m_pc;
      chk("idle_ready", bus.req_ready, 1);
      chk("idle_done", bus.done, 0);
      chk("idle_strobes", {bus.opcode_update, bus.imem_update, bus.dmem_update}, 0);
      chk("idle_pc", bus.pc, m_pc);
      chk("idle_imem_data", bus.imem_data, m_ihold);
      chk("idle_dmem_data", bus.dmem_data, m_dhold);
      chk("idle_imem_en", bus.imem_en, bus.req_valid && !bus.req_op[1]);
      chk("idle_dmem_en", bus.dmem_en, bus.req_valid && bus.req_op[1]);
      chk("idle_dmem_we", bus.dmem_we, bus.req_valid && bus.req_op == 2'b11);
      if (bus.imem_en) chk("idle_imem_addr", bus.imem_addr, faddr);
      if (bus.dmem_en) chk("idle_dmem_addr", bus.dmem_addr, bus.req_addr);
      if (bus.dmem_we) chk("idle_dmem_wdata", bus.dmem_wdata, bus.req_wdata);
      if (bus.jump) m_pc = bus.jump_addr;
      if (bus.req_valid) begin
        m_busy = 1;
        m_kind = bus.req_op;
        m_faddr = faddr;
        m_laddr = bus.req_addr;
        if (bus.req_op == 2'b11) shadow[bus.req_addr] = bus.req_wdata;
        $display("t=%0t accept op=%0d iaddr=%0h daddr=%0h wdata=%0h", $time,
                 bus.req_op, faddr, bus.req_addr, bus.req_wdata);
      end
    end else begin
      logic [15:0] ei;
      logic [7:0]  ed;
      ei = (m_kind < 2) ? imem[m_faddr] : m_ihold;
      ed = (m_kind == 2) ? shadow[m_laddr] : m_dhold;
      chk("busy_ready", bus.req_ready, 0);
      chk("busy_done", bus.done, 1);
      chk("busy_mem_en", {bus.imem_en, bus.dmem_en, bus.dmem_we}, 0);
      chk("busy_opcode_update", bus.opcode_update, m_kind == 0);
      chk("busy_imem_update", bus.imem_update, m_kind == 1);
      chk("busy_dmem_update", bus.dmem_update, m_kind == 2);
      chk("busy_pc", bus.pc, m_pc);
      chk("busy_imem_data", bus.imem_data, ei);
      chk("busy_dmem_data", bus.dmem_data, ed);
      m_ihold = ei;
      m_dhold = ed;
      m_busy = 0;
      if (m_kind < 2) m_pc = m_pc + 8'd1;
    end
  end

  task automatic drive(input bit v, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] wd, input bit j, input logic [7:0] ja);
    bus.req_valid = v; bus.req_op = op; bus.req_addr = a;
    bus.req_wdata = wd; bus.jump = j; bus.jump_addr = ja;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'($urandom());
      dmem[i] = 8'($urandom());
      shadow[i] = dmem[i];
    end
    imem[8'h10] = 16'hA5C3;
    bus.imem_rdata = '0;
    bus.dmem_rdata = '0;
    drive(0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // FETCH_OP from the reset PC
    drive(1, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    #1 chk("pin_fetch_addr", bus.imem_addr, 8'h10);
    step();
    drive(0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    chk("pin_opcode_update", bus.opcode_update, 1);
    chk("pin_imem_data", bus.imem_data, 16'hA5C3);
    chk("pin_done", bus.done, 1);
    step();
    chk("pin_pc_inc", bus.pc, 8'h11);
    chk("pin_ready_back", bus.req_ready, 1);

    // PC wrap on FETCH_IMM from 0xFF
    drive(0, 2'b00, 8'h00, 8'h00, 1, 8'hFF);
    step();
    drive(1, 2'b01, 8'h00, 8'h00, 0, 8'h00);
    step();
    drive(0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    chk("pin_imm_update", bus.imem_update, 1);
    chk("pin_imm_no_opcode", bus.opcode_update, 0);
    step();
    chk("pin_pc_wrap", bus.pc, 8'h00);

    // Jump with same-cycle fetch, then a jump ignored during IREAD
    drive(1, 2'b00, 8'h00, 8'h00, 1, 8'h40);
    #1 chk("pin_jump_fetch_addr", bus.imem_addr, 8'h40);
    step();
    drive(1, 2'b10, 8'h03, 8'h00, 1, 8'h77);
    step();
    chk("pin_jump_pc", bus.pc, 8'h41);
    drive(0, 2'b00, 8'h00, 8'h00, 0, 8'h00);

    // STORE then LOAD of the same address
    drive(1, 2'b11, 8'h22, 8'h5A, 0, 8'h00);
    #1;
    chk("pin_store_we", bus.dmem_we, 1);
    chk("pin_store_addr", bus.dmem_addr, 8'h22);
    chk("pin_store_wdata", bus.dmem_wdata, 8'h5A);
    step();
    drive(0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    step();
    drive(1, 2'b10, 8'h22, 8'h00, 0, 8'h00);
    step();
    drive(0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    chk("pin_load_update", bus.dmem_update, 1);
    chk("pin_load_data", bus.dmem_data, 8'h5A);
    step();
    chk("pin_ldst_pc", bus.pc, 8'h41);

    // Reset during IREAD, then during DREAD
    drive(1, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    step();
    drive(0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    rst = 1'b0;
    #1;
    chk("pin_abort_done", bus.done, 0);
    chk("pin_abort_strobe", bus.opcode_update, 0);
    chk("pin_abort_pc", bus.pc, RPC);
    chk("pin_abort_ready", bus.req_ready, 1);
    step();
    rst = 1'b1;
    step();
    drive(1, 2'b10, 8'h05, 8'h00, 0, 8'h00);
    step();
    drive(0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    rst = 1'b0;
    #1;
    chk("pin_abort_dupdate", bus.dmem_update, 0);
    chk("pin_abort_ddone", bus.done, 0);
    step();
    rst = 1'b1;
    step();

    // Randomized traffic with jumps, wraps and occasional resets
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
            8'($urandom_range(0, 15)), 8'($urandom()),
            $urandom_range(0, 9) < 2,
            ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom()));
      rst = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      step();
    end
    rst = 1'b1;
    drive(0, 2'b00, 8'h00, 8'h00, 0, 8'h00);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
